// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response handshake plus byte-lane RAM port of the load/store controller.
// slave = controller view, master = core + RAM environment view.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [2:0]            i_funct3;
    logic [31:0]           i_addr;
    logic [31:0]           i_wdata;
    logic                  o_resp_valid;
    logic                  i_resp_ready;
    logic [31:0]           o_resp_rdata;
    logic                  o_resp_err;
    logic                  o_ram_read_req;
    logic [ADDR_WIDTH:0]   o_ram_read_addr;
    logic [DATA_WIDTH:0]   i_ram_read_data;
    logic                  o_ram_write_enable;
    logic [3:0]            o_ram_byte_enable;
    logic [ADDR_WIDTH:0]   o_ram_write_addr;
    logic [DATA_WIDTH:0]   o_ram_write_data;

    modport slave (
        input  i_req_valid, i_req_we, i_funct3, i_addr, i_wdata, i_resp_ready, i_ram_read_data,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
               o_ram_read_req, o_ram_read_addr, o_ram_write_enable, o_ram_byte_enable,
               o_ram_write_addr, o_ram_write_data
    );

    modport master (
        output i_req_valid, i_req_we, i_funct3, i_addr, i_wdata, i_resp_ready, i_ram_read_data,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
               o_ram_read_req, o_ram_read_addr, o_ram_write_enable, o_ram_byte_enable,
               o_ram_write_addr, o_ram_write_data
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: decodes one request into a single RAM access,
// then aligns/extends load data and returns a response with an error flag.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    lsu_mem_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, STORE, LOAD_REQ, LOAD_WAIT, RESP} state_t;

    state_t              state;
    logic [2:0]          f3_q;
    logic [1:0]          lo_q;
    logic [ADDR_WIDTH:0] word_addr;
    logic                err_c;
    logic [3:0]          be_c;
    logic [31:0]         wd_c;
    logic [31:0]         ld_sh;
    logic [31:0]         ld_ext;

    // Word address: drop the byte offset, zero-extend when the RAM port is wider.
    generate
        if (ADDR_WIDTH >= 30) begin : g_wa_ext
            assign word_addr = {{(ADDR_WIDTH - 29){1'b0}}, bus.i_addr[31:2]};
        end else begin : g_wa_trunc
            assign word_addr = bus.i_addr[ADDR_WIDTH+2:2];
        end
    endgenerate

    assign bus.o_req_ready = !rst && (state == IDLE);

    always_comb begin
        logic illegal;
        logic misalign;
        illegal  = bus.i_req_we ? (bus.i_funct3 > 3'd2)
                                : (bus.i_funct3 == 3'd3 || bus.i_funct3 >= 3'd6);
        misalign = 1'b0;
        be_c     = 4'b0000;
        wd_c     = bus.i_wdata;
        case (bus.i_funct3[1:0])
            2'd0: begin
                be_c = 4'b0001 << bus.i_addr[1:0];
                wd_c = {4{bus.i_wdata[7:0]}};
            end
            2'd1: begin
                misalign = bus.i_addr[0];
                be_c     = bus.i_addr[1] ? 4'b1100 : 4'b0011;
                wd_c     = {2{bus.i_wdata[15:0]}};
            end
            2'd2: begin
                misalign = (bus.i_addr[1:0] != 2'b00);
                be_c     = 4'b1111;
            end
            default: ;
        endcase
        err_c = illegal || misalign;
    end

    // Load lane alignment and extension from the latched funct3/offset.
    always_comb begin
        ld_sh = bus.i_ram_read_data >> {lo_q, 3'b000};
        case (f3_q)
            3'd0:    ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'd1:    ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'd4:    ld_ext = {24'd0, ld_sh[7:0]};
            3'd5:    ld_ext = {16'd0, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            f3_q                   <= '0;
            lo_q                   <= '0;
            bus.o_resp_valid       <= 1'b0;
            bus.o_resp_rdata       <= '0;
            bus.o_resp_err         <= 1'b0;
            bus.o_ram_read_req     <= 1'b0;
            bus.o_ram_read_addr    <= '0;
            bus.o_ram_write_enable <= 1'b0;
            bus.o_ram_byte_enable  <= '0;
            bus.o_ram_write_addr   <= '0;
            bus.o_ram_write_data   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (bus.i_req_valid) begin
                    f3_q <= bus.i_funct3;
                    lo_q <= bus.i_addr[1:0];
                    if (err_c) begin
                        bus.o_resp_valid <= 1'b1;
                        bus.o_resp_err   <= 1'b1;
                        bus.o_resp_rdata <= '0;
                        state            <= RESP;
                    end else if (bus.i_req_we) begin
                        bus.o_ram_write_addr   <= word_addr;
                        bus.o_ram_write_data   <= wd_c;
                        bus.o_ram_byte_enable  <= be_c;
                        bus.o_ram_write_enable <= 1'b1;
                        state                  <= STORE;
                    end else begin
                        bus.o_ram_read_addr <= word_addr;
                        bus.o_ram_read_req  <= 1'b1;
                        state               <= LOAD_REQ;
                    end
                end
                STORE: begin
                    bus.o_ram_write_enable <= 1'b0;
                    bus.o_resp_valid       <= 1'b1;
                    bus.o_resp_err         <= 1'b0;
                    bus.o_resp_rdata       <= '0;
                    state                  <= RESP;
                end
                LOAD_REQ: begin
                    bus.o_ram_read_req <= 1'b0;
                    state              <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    bus.o_resp_rdata <= ld_ext;
                    bus.o_resp_err   <= 1'b0;
                    bus.o_resp_valid <= 1'b1;
                    state            <= RESP;
                end
                RESP: if (bus.i_resp_ready) begin
                    bus.o_resp_valid <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-lane RAM model and a vector table.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic mem_init;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    // RAM model: byte-lane writes, registered reads; word i preloads {7000+i, 9000+i}.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= {16'h7000 + 16'(i), 16'h9000 + 16'(i)};
        end else begin
            if (bus.o_ram_write_enable)
                for (int b = 0; b < 4; b++)
                    if (bus.o_ram_byte_enable[b])
                        mem[bus.o_ram_write_addr[5:0]][8*b +: 8] <= bus.o_ram_write_data[8*b +: 8];
            if (bus.o_ram_read_req) bus.i_ram_read_data <= mem[bus.o_ram_read_addr[5:0]];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = we;
        bus.i_funct3    = f3;
        bus.i_addr      = a;
        bus.i_wdata     = wd;
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int lat = 0, nrd = 0, nwr = 0;
        logic got = 1'b0;
        logic [31:0] ra = '0, wa = '0, wd = '0;
        logic [3:0] be = '0;
        @(negedge clk);
        chk({tag, "_req_ready"}, bus.o_req_ready, 1);
        drive_req(v.we, v.f3, v.addr, v.wdata);
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.o_ram_read_req) begin nrd++; ra = bus.o_ram_read_addr; end
            if (bus.o_ram_write_enable) begin
                nwr++; be = bus.o_ram_byte_enable; wa = bus.o_ram_write_addr; wd = bus.o_ram_write_data;
            end
            if (bus.o_resp_valid) got = 1'b1;
        end
        chk({tag, "_resp_seen"}, got, 1);
        if (got) begin
            chk({tag, "_lat"}, lat, v.exp_lat);
            chk({tag, "_rdata"}, bus.o_resp_rdata, v.exp_rdata);
            chk({tag, "_err"}, bus.o_resp_err, v.exp_err);
            chk({tag, "_nrd"}, nrd, (!v.we && !v.exp_err) ? 1 : 0);
            chk({tag, "_nwr"}, nwr, (v.we && !v.exp_err) ? 1 : 0);
            if (!v.exp_err && v.we) begin
                chk({tag, "_be"}, be, v.exp_be);
                chk({tag, "_waddr"}, wa, v.addr >> 2);
                chk({tag, "_wdata"}, wd, v.exp_wdata);
            end
            if (!v.exp_err && !v.we) chk({tag, "_raddr"}, ra, v.addr >> 2);
            bus.i_resp_ready = 1'b1;
            @(posedge clk);
            #1 bus.i_resp_ready = 1'b0;
        end
    endtask

    initial begin
        int w;
        vt[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4'hF, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4'h0, 32'h0};
        vt[2]  = '{1'b1, 3'd0, 32'h13, 32'h123456A5, 32'h0,        1'b0, 2, 4'h8, 32'hA5A5A5A5};
        vt[3]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0, 3, 4'h0, 32'h0};
        vt[4]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h000000A5, 1'b0, 3, 4'h0, 32'h0};
        vt[5]  = '{1'b1, 3'd1, 32'h22, 32'hFFFF8001, 32'h0,        1'b0, 2, 4'hC, 32'h80018001};
        vt[6]  = '{1'b0, 3'd1, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0, 32'h0};
        vt[7]  = '{1'b0, 3'd5, 32'h20, 32'h0,        32'h00009008, 1'b0, 3, 4'h0, 32'h0};
        vt[8]  = '{1'b0, 3'd2, 32'h06, 32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};
        vt[9]  = '{1'b1, 3'd1, 32'h05, 32'hFFFF,     32'h0,        1'b1, 1, 4'h0, 32'h0};
        vt[10] = '{1'b0, 3'd3, 32'h00, 32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};
        vt[11] = '{1'b1, 3'd4, 32'h00, 32'h1,        32'h0,        1'b1, 1, 4'h0, 32'h0};
        vt[12] = '{1'b0, 3'd0, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 4'h0, 32'h0};
        vt[13] = '{1'b0, 3'd5, 32'h12, 32'h0,        32'h0000A5AD, 1'b0, 3, 4'h0, 32'h0};
        vt[14] = '{1'b1, 3'd0, 32'h21, 32'hFFFFFFC3, 32'h0,        1'b0, 2, 4'h2, 32'hC3C3C3C3};
        vt[15] = '{1'b0, 3'd2, 32'h20, 32'h0,        32'h8001C308, 1'b0, 3, 4'h0, 32'h0};
        vt[16] = '{1'b0, 3'd6, 32'h00, 32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0};

        rst = 1'b1; clk_en = 1'b1; mem_init = 1'b1;
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_funct3 = '0;
        bus.i_addr = '0; bus.i_wdata = '0; bus.i_resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.o_req_ready, 0);
        chk("rst_resp_valid", bus.o_resp_valid, 0);
        chk("rst_read_req", bus.o_ram_read_req, 0);
        chk("rst_write_en", bus.o_ram_write_enable, 0);
        chk("rst_rdata", bus.o_resp_rdata, 0);
        mem_init = 1'b0;
        rst = 1'b0;
        #1 chk("rel_req_ready", bus.o_req_ready, 1);

        for (int i = 0; i < 17; i++) run_txn($sformatf("v%0d", i), vt[i]);

        // Load stalled by clk_en low in LOAD_REQ and by a slow response consumer.
        drive_req(1'b0, 3'd2, 32'h10, 32'h0);
        @(negedge clk);
        chk("stall_rd_issue", bus.o_ram_read_req, 1);
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_rd_hold%0d", k), bus.o_ram_read_req, 1);
            chk($sformatf("stall_no_resp%0d", k), bus.o_resp_valid, 0);
        end
        clk_en = 1'b1;
        w = 0;
        while (!bus.o_resp_valid && w < 10) begin @(negedge clk); w++; end
        chk("stall_resp_wait", w, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_valid%0d", k), bus.o_resp_valid, 1);
            chk($sformatf("stall_rdata%0d", k), bus.o_resp_rdata, 32'hA5ADBEEF);
            chk($sformatf("stall_ready%0d", k), bus.o_req_ready, 0);
        end
        clk_en = 1'b0;
        bus.i_resp_ready = 1'b1;
        @(negedge clk);
        chk("stall_ce_hold", bus.o_resp_valid, 1);
        clk_en = 1'b1;
        @(posedge clk);
        #1 bus.i_resp_ready = 1'b0;
        chk("stall_done_valid", bus.o_resp_valid, 0);
        chk("stall_done_ready", bus.o_req_ready, 1);

        // Reset during STORE.
        drive_req(1'b1, 3'd2, 32'h30, 32'h11223344);
        @(negedge clk);
        chk("rs_we_issued", bus.o_ram_write_enable, 1);
        rst = 1'b1;
        #1;
        chk("rs_we_drop", bus.o_ram_write_enable, 0);
        chk("rs_resp_valid", bus.o_resp_valid, 0);
        chk("rs_req_ready", bus.o_req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rs_idle", bus.o_req_ready, 1);

        // Reset during LOAD_REQ, then during LOAD_WAIT.
        drive_req(1'b0, 3'd2, 32'h30, 32'h0);
        @(negedge clk);
        chk("rl_rd_issued", bus.o_ram_read_req, 1);
        rst = 1'b1;
        #1 chk("rl_rd_drop", bus.o_ram_read_req, 0);
        @(negedge clk);
        rst = 1'b0;
        drive_req(1'b0, 3'd2, 32'h30, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_rd_low", bus.o_ram_read_req, 0);
        chk("rw_resp_valid", bus.o_resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rw_idle", bus.o_req_ready, 1);

        run_txn("post_sw", '{1'b1, 3'd2, 32'h30, 32'h55667788, 32'h0, 1'b0, 2, 4'hF, 32'h55667788});
        run_txn("post_lw", '{1'b0, 3'd2, 32'h30, 32'h0, 32'h55667788, 1'b0, 3, 4'h0, 32'h0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
